// File: rtl/dma_arbiter.sv
// Two-requester DMA arbiter: hold/hlda bus handshake, round-robin ties,
// tenure timeout with per-requester lockout, gated write path.
// Ports: clk, rst (sync, high); req0/req1, we0/we1, d0/d1 from requesters;
// hlda from control matrix; hold, appr0/appr1, we_out, d_out, busy, tmo.
module dma_arbiter #(
  parameter int          width   = 16,
  parameter logic [7:0]  timeout = 8'd200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       we0,
  input  logic [2:0]       we1,
  input  logic [width-1:0] d0,
  input  logic [width-1:0] d1,
  input  logic             hlda,
  output logic             hold,
  output logic             appr0,
  output logic             appr1,
  output logic [2:0]       we_out,
  output logic [width-1:0] d_out,
  output logic             busy,
  output logic             tmo
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_GRANT,
    ST_REL
  } state_t;

  state_t     state;
  state_t     nxt;
  logic       win;
  logic       nxt_win;
  logic       last;
  logic       lock0;
  logic       lock1;
  logic [7:0] cnt;
  logic       el0;
  logic       el1;
  logic       req_w;
  logic       g_exit;
  logic       tmo_evt;
  logic       gnt;

  assign el0   = req0 & ~lock0;
  assign el1   = req1 & ~lock1;
  assign req_w = win ? req1 : req0;

  always_comb begin
    nxt     = state;
    nxt_win = win;
    g_exit  = 1'b0;
    tmo_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (el0 | el1) begin
          nxt = ST_HOLD;
          // On a tie, the requester not served last wins.
          if (el0 & el1) nxt_win = ~last;
          else           nxt_win = el1;
        end
      end
      ST_HOLD: begin
        if (!req_w)    nxt = ST_REL;
        else if (hlda) nxt = ST_GRANT;
      end
      ST_GRANT: begin
        // A voluntary drop or revocation outranks the timeout.
        if (!req_w || !hlda) begin
          nxt    = ST_REL;
          g_exit = 1'b1;
        end else if (cnt == timeout - 8'd1) begin
          nxt     = ST_REL;
          g_exit  = 1'b1;
          tmo_evt = 1'b1;
        end
      end
      ST_REL: begin
        if (!hlda) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      win   <= 1'b0;
      last  <= 1'b1;
      lock0 <= 1'b0;
      lock1 <= 1'b0;
      cnt   <= 8'd0;
      hold  <= 1'b0;
      appr0 <= 1'b0;
      appr1 <= 1'b0;
      busy  <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      state <= nxt;
      win   <= nxt_win;
      if (g_exit) last <= win;
      if (tmo_evt && !win) lock0 <= 1'b1;
      else if (!req0)      lock0 <= 1'b0;
      if (tmo_evt && win)  lock1 <= 1'b1;
      else if (!req1)      lock1 <= 1'b0;
      // Zero outside GRANT, so it is already clear on entry.
      if (state == ST_GRANT) cnt <= cnt + 8'd1;
      else                   cnt <= 8'd0;
      hold  <= (nxt == ST_HOLD) || (nxt == ST_GRANT);
      appr0 <= (nxt == ST_GRANT) && !nxt_win;
      appr1 <= (nxt == ST_GRANT) && nxt_win;
      busy  <= (nxt != ST_IDLE);
      tmo   <= tmo_evt;
    end
  end

  assign gnt    = (state == ST_GRANT) && hlda;
  assign we_out = gnt ? (win ? we1 : we0) : 3'b000;
  assign d_out  = gnt ? (win ? d1 : d0) : '0;

endmodule
